// File: rtl/sync_fifo_reader.sv
// Drain side of the synchronous FIFO: pops words into a small buffer and presents them on valid/ready.
// Optional delivered-word counter (word_cnt_o) is built when SYNC_FIFO_RDR_STATS_EN is defined.
module sync_fifo_reader #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned BUF_DEPTH = 2
`ifdef SYNC_FIFO_RDR_STATS_EN
    ,
    parameter int unsigned CNT_W     = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_rd_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             idle_o
`ifdef SYNC_FIFO_RDR_STATS_EN
    ,
    output logic [CNT_W-1:0] word_cnt_o
`endif
);

    localparam int unsigned IdxW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = IdxW + 2;

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [IdxW-1:0]  rd_idx_q;
    logic [IdxW-1:0]  wr_idx_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic             inflight_q;
    logic             pop;

    // Occupancy after this cycle's capture/pop; a same-cycle pop frees room for a new read.
    always_comb begin
        pop       = m_valid_o & m_ready_i;
        count_d   = count_q + CntW'(inflight_q) - CntW'(pop);
        fifo_rd_o = reset & enable_i & ~fifo_empty_i & (count_d < CntW'(BUF_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= fifo_rd_o;
            count_q    <= count_d;
            if (inflight_q) begin
                mem_q[wr_idx_q] <= fifo_data_i;
                wr_idx_q        <= wr_idx_q + 1'b1;
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        m_valid_o = (count_q != '0);
        m_data_o  = mem_q[rd_idx_q];
        idle_o    = (count_q == '0) & ~inflight_q;
    end

`ifdef SYNC_FIFO_RDR_STATS_EN
    logic [CNT_W-1:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_cnt_q <= '0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader against a behavioural FIFO with 1-cycle registered read data.
// Word-counter checks are compiled in when SYNC_FIFO_RDR_STATS_EN is defined.
module tb_sync_fifo_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         fifo_empty;
    logic [127:0] fifo_data = '0;
    logic         fifo_rd;
    logic         m_valid;
    logic [127:0] m_data;
    logic         m_ready;
    logic         idle;
`ifdef SYNC_FIFO_RDR_STATS_EN
    logic [31:0]  word_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] mem [64];
    int wp = 0;
    int rp = 0;

    always #5 clk = ~clk;

    sync_fifo_reader dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rd_o    (fifo_rd),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_ready_i    (m_ready),
        .idle_o       (idle)
`ifdef SYNC_FIFO_RDR_STATS_EN
        ,
        .word_cnt_o   (word_cnt)
`endif
    );

    // Upstream FIFO: data appears the cycle after the strobe.
    assign fifo_empty = (rp == wp);
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rp];
            rp        <= rp + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic push(input logic [127:0] v);
        mem[wp] = v;
        wp++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) check("occ_le_depth", 128'(dut.count_q <= 2), 128'd1);

    initial begin
        int nrd;
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(128'(i));

        // Reset held with a non-empty FIFO.
        tick(); tick(); #1;
        check("rst_rd", fifo_rd, 0);
        check("rst_vld", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_idle", idle, 1);
`ifdef SYNC_FIFO_RDR_STATS_EN
        check("rst_wcnt", word_cnt, 0);
`endif

        // Full-rate stream of 8 words.
        tick(); reset = 1'b1; #1;
        for (int i = 0; i < 10; i++) begin
            check("s_rd", fifo_rd, 128'(i < 8));
            check("s_vld", m_valid, 128'(i >= 2));
            if (i >= 2) check("s_data", m_data, 128'(i - 1));
            tick(); #1;
        end
        check("s_vld_end", m_valid, 0);
        check("s_idle_end", idle, 1);
`ifdef SYNC_FIFO_RDR_STATS_EN
        check("s_wcnt", word_cnt, 8);
`endif

        // Backpressure: only BUF_DEPTH reads go out, head held stable.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(128'(i));
        #1;
        nrd = 0;
        for (int i = 0; i < 6; i++) begin
            nrd += int'(fifo_rd);
            tick(); #1;
        end
        check("bp_nrd", 128'(nrd), 2);
        check("bp_vld", m_valid, 1);
        check("bp_data", m_data, 1);
        check("bp_rd_full", fifo_rd, 0);
        tick(); #1;
        check("bp_stable", m_data, 1);
        m_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_vld", m_valid, 1);
            check("bp_drain_data", m_data, 128'(i + 1));
            tick(); #1;
        end
        check("bp_vld_end", m_valid, 0);
`ifdef SYNC_FIFO_RDR_STATS_EN
        check("bp_wcnt", word_cnt, 13);
`endif

        // Empty FIFO.
        for (int i = 0; i < 3; i++) begin
            check("e_rd", fifo_rd, 0);
            check("e_vld", m_valid, 0);
            check("e_idle", idle, 1);
            tick(); #1;
        end

        // Enable drops the cycle after a read.
        push(128'hA); push(128'hB); push(128'hC);
        #1;
        check("en_rd0", fifo_rd, 1);
        tick(); enable = 1'b0; #1;
        check("en_rd1", fifo_rd, 0);
        check("en_busy", idle, 0);
        tick(); #1;
        check("en_vld", m_valid, 1);
        check("en_data", m_data, 128'hA);
        tick(); #1;
        check("en_vld_end", m_valid, 0);
        check("en_idle", idle, 1);
        check("en_rd2", fifo_rd, 0);
        tick(); #1;
        check("en_rd3", fifo_rd, 0);
`ifdef SYNC_FIFO_RDR_STATS_EN
        check("en_wcnt", word_cnt, 14);
`endif

        // Reset while a read is in flight: B, C queued in FIFO plus D, E.
        push(128'hD); push(128'hE);
        m_ready = 1'b0; enable = 1'b1; #1;
        check("mr_rd0", fifo_rd, 1);
        tick(); #1;
        check("mr_rd1", fifo_rd, 1);
        tick(); #1;
        check("mr_rd2", fifo_rd, 0);
        tick(); #1;
        check("mr_vld", m_valid, 1);
        check("mr_data", m_data, 128'hB);
        m_ready = 1'b1; #1;
        check("mr_rd3", fifo_rd, 1);
        tick(); m_ready = 1'b0; reset = 1'b0; #1;
        check("mr_rd_rst", fifo_rd, 0);
        check("mr_busy", idle, 0);
        tick(); #1;
        check("mr_vld_rst", m_valid, 0);
        check("mr_idle_rst", idle, 1);
        check("mr_data_rst", m_data, 0);
`ifdef SYNC_FIFO_RDR_STATS_EN
        check("mr_wcnt_rst", word_cnt, 0);
`endif
        reset = 1'b1; enable = 1'b0; #1;
        check("mr_rd_off", fifo_rd, 0);
        tick(); #1;
        check("mr_discard", m_valid, 0);
        enable = 1'b1; m_ready = 1'b1; #1;
        check("mr_rd_e", fifo_rd, 1);
        tick(); #1;
        tick(); #1;
        check("mr_vld_e", m_valid, 1);
        check("mr_data_e", m_data, 128'hE);
        tick(); #1;
`ifdef SYNC_FIFO_RDR_STATS_EN
        check("mr_wcnt_e", word_cnt, 1);
`endif
        check("mr_idle_end", idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
